// File: rtl/uart_dec_streamer.sv
// Converts each received byte to decimal ASCII plus a separator, queues the text in a
// byte FIFO and feeds it to uart_tx. Optional macro DEC_ZERO_SUPPRESS_EN drops leading zeros.
module uart_dec_streamer #(
    parameter int         DEPTH    = 16,
    parameter int         ADDR_W   = 4,
    parameter logic [7:0] SEP_CHAR = 8'h20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_done,
    output logic [ADDR_W:0]   fifo_level,
    output logic              dropped
);

    typedef enum logic [2:0] {
        IDLE, HUND, TENS, EMIT_H, EMIT_T, EMIT_U, EMIT_S
    } conv_state_t;

    typedef enum logic {
        T_IDLE, T_WAIT
    } tx_state_t;

    localparam logic [ADDR_W:0]   DEPTH_LVL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   MIN_FREE  = (ADDR_W+1)'(4);
    localparam logic [ADDR_W:0]   LVL_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    conv_state_t           cs, cs_nxt;
    tx_state_t             ts, ts_nxt;
    logic [7:0]            val;
    logic [3:0]            h, t;
    logic [7:0]            mem [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr, rd_ptr;
    logic [ADDR_W:0]       free_slots;
    logic                  accept, push, pop;
    logic [7:0]            push_byte;

    assign free_slots = DEPTH_LVL - fifo_level;
    assign in_ready   = (cs == IDLE) && (free_slots >= MIN_FREE);
    assign accept     = in_valid && in_ready;
    assign pop        = (ts == T_IDLE) && (fifo_level != '0);

    // Convert FSM: repeated subtraction, then one push per emit state
    always_comb begin
        cs_nxt    = cs;
        push      = 1'b0;
        push_byte = 8'h00;
        unique case (cs)
            IDLE: begin
                if (accept) cs_nxt = HUND;
            end
            HUND: begin
                if (val < 8'd100) cs_nxt = TENS;
            end
            TENS: begin
                if (val < 8'd10) begin
`ifdef DEC_ZERO_SUPPRESS_EN
                    if (h != 4'd0)      cs_nxt = EMIT_H;
                    else if (t != 4'd0) cs_nxt = EMIT_T;
                    else                cs_nxt = EMIT_U;
`else
                    cs_nxt = EMIT_H;
`endif
                end
            end
            EMIT_H: begin
                push      = 1'b1;
                push_byte = ascii_digit(h);
                cs_nxt    = EMIT_T;
            end
            EMIT_T: begin
                push      = 1'b1;
                push_byte = ascii_digit(t);
                cs_nxt    = EMIT_U;
            end
            EMIT_U: begin
                push      = 1'b1;
                push_byte = ascii_digit(val[3:0]);
                cs_nxt    = EMIT_S;
            end
            EMIT_S: begin
                push      = 1'b1;
                push_byte = SEP_CHAR;
                cs_nxt    = IDLE;
            end
            default: cs_nxt = IDLE;
        endcase
    end

    // TX FSM: one byte in flight at a time, released by tx_done
    always_comb begin
        ts_nxt = ts;
        unique case (ts)
            T_IDLE:  if (pop) ts_nxt = T_WAIT;
            T_WAIT:  if (tx_done) ts_nxt = T_IDLE;
            default: ts_nxt = T_IDLE;
        endcase
    end

    // Digit datapath; contents are don't-care until a byte is latched
    always_ff @(posedge clk) begin
        unique case (cs)
            IDLE: begin
                if (accept) begin
                    val <= in_data;
                    h   <= 4'd0;
                    t   <= 4'd0;
                end
            end
            HUND: begin
                if (val >= 8'd100) begin
                    val <= val - 8'd100;
                    h   <= h + 4'd1;
                end
            end
            TENS: begin
                if (val >= 8'd10) begin
                    val <= val - 8'd10;
                    t   <= t + 4'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_byte;
    end

    // Control state, FIFO bookkeeping and uart_tx interface
    always_ff @(posedge clk) begin
        if (reset) begin
            cs         <= IDLE;
            ts         <= T_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            dropped    <= 1'b0;
        end else begin
            cs       <= cs_nxt;
            ts       <= ts_nxt;
            tx_start <= pop;
            if (in_valid && !in_ready) dropped <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                tx_data <= mem[rd_ptr];
            end
            unique case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_ONE;
                2'b01:   fifo_level <= fifo_level - LVL_ONE;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_dec_streamer.sv
// Scoreboard bench for uart_dec_streamer: expected text queued at byte acceptance,
// checked by a monitor on every tx_start; a responder process models uart_tx tx_done.
module tb_uart_dec_streamer;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_done;
    logic [ADDR_W:0]   fifo_level;
    logic              dropped;

    logic auto_done, man_done, hold_done, resp_busy, in_flight;
    logic [7:0] last_start;
    logic [7:0] exp_q[$];
    int checks = 0, passes = 0, start_cnt = 0, exp_pushed = 0;

    assign tx_done = auto_done | man_done;

    always #5 clk = ~clk;

    uart_dec_streamer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .SEP_CHAR(8'h20)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
        .fifo_level(fifo_level), .dropped(dropped)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // Reference decimal formatter
    task automatic expect_dec(input logic [7:0] v);
        int hd, td, ud;
        hd = int'(v) / 100;
        td = (int'(v) / 10) % 10;
        ud = int'(v) % 10;
`ifdef DEC_ZERO_SUPPRESS_EN
        if (hd != 0) begin exp_q.push_back(8'(48 + hd)); exp_pushed++; end
        if (hd != 0 || td != 0) begin exp_q.push_back(8'(48 + td)); exp_pushed++; end
`else
        exp_q.push_back(8'(48 + hd));
        exp_q.push_back(8'(48 + td));
        exp_pushed += 2;
`endif
        exp_q.push_back(8'(48 + ud));
        exp_q.push_back(8'h20);
        exp_pushed += 2;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_tx_start"}, tx_start, 0);
        check({tag, "_tx_data"}, tx_data, 8'h00);
        check({tag, "_fifo_level"}, fifo_level, 0);
        check({tag, "_dropped"}, dropped, 0);
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals(tag);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (!in_ready && n < 500) begin @(negedge clk); n++; end
        if (!in_ready) begin
            checks++;
            $display("FAIL send_timeout: in_ready=0 required=1");
        end else begin
            in_data  = b;
            in_valid = 1'b1;
            expect_dec(b);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (!(exp_q.size() == 0 && fifo_level == 0 && in_ready && !resp_busy && !tx_start)
               && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        if (n >= 3000) begin
            checks++;
            $display("FAIL %s_drain: pending=%0d required=0", tag, exp_q.size());
        end
    endtask

    // uart_tx stand-in: tx_done 20 cycles after each start, unless held
    initial begin
        auto_done = 1'b0;
        resp_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start && !reset) begin
                resp_busy = 1'b1;
                repeat (20) @(negedge clk);
                while (hold_done) @(negedge clk);
                auto_done = 1'b1;
                @(negedge clk);
                auto_done = 1'b0;
                resp_busy = 1'b0;
            end
        end
    end

    // Monitor: every tx_start consumes one expected byte
    initial begin
        logic [7:0] e;
        in_flight = 1'b0;
        last_start = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_flight = 1'b0;
            end else begin
                if (tx_done && in_flight && !tx_start) begin
                    check("tx_data_hold", tx_data, last_start);
                    in_flight = 1'b0;
                end
                if (tx_start) begin
                    start_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_tx_start: tx_data=%0h required=no start", tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_byte", tx_data, e);
                    end
                    last_start = tx_data;
                    in_flight  = 1'b1;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, p0, low, n;
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        man_done = 1'b0; hold_done = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b0;
        @(negedge clk);

        // 65 -> "065 "
        s0 = start_cnt; p0 = exp_pushed;
        send_byte(8'h41);
        wait_drain("b65");
        check("b65_starts", start_cnt - s0, exp_pushed - p0);
        check("b65_level", fifo_level, 0);

        // 255: HUND 3 + TENS 6 + 4 emit cycles with in_ready low
        send_byte(8'd255);
        low = 0;
        while (!in_ready && low < 40) begin low++; @(negedge clk); end
        check("b255_busy_cycles", low, 13);
        wait_drain("b255");

        send_byte(8'd0);
        wait_drain("b0");

        // Strobe during conversion is dropped and sticky
        send_byte(8'd1);
        repeat (2) @(negedge clk);
        check("drop_in_ready", in_ready, 0);
        in_data = 8'd2; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("drop_set", dropped, 1);
        wait_drain("drop");
        check("drop_sticky", dropped, 1);
        pulse_reset("rst_drop");

        // Fill with tx_done withheld
        hold_done = 1'b1;
        s0 = start_cnt; p0 = exp_pushed;
        send_byte(8'd123);
        send_byte(8'd145);
        send_byte(8'd206);
        send_byte(8'd200);
        repeat (20) @(negedge clk);
        check("fill_level", fifo_level, 15);
        check("fill_in_ready", in_ready, 0);
        in_data = 8'd77; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("fill_dropped", dropped, 1);
        hold_done = 1'b0;
        wait_drain("fill");
        check("fill_starts", start_cnt - s0, 16);
        pulse_reset("rst_fill");

        // Push and pop in the same cycle
        hold_done = 1'b1;
        s0 = start_cnt;
        send_byte(8'd123);
        send_byte(8'd104);
        repeat (4) @(negedge clk);
        check("pp_level_emit_t", fifo_level, 4);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        check("pp_level_emit_u", fifo_level, 5);
        @(negedge clk);
        check("pp_level_same", fifo_level, 5);
        hold_done = 1'b0;
        wait_drain("pp");
        check("pp_starts", start_cnt - s0, 8);

        // Reset during TENS
        send_byte(8'd99);
        repeat (2) @(negedge clk);
        pulse_reset("rst_tens");
        repeat (10) @(negedge clk);
        check("rst_tens_level", fifo_level, 0);

        // Reset during T_WAIT; stale tx_done must be ignored
        send_byte(8'd50);
        n = 0;
        while (!in_flight && n < 100) begin @(negedge clk); n++; end
        check("twait_started", in_flight, 1);
        repeat (3) @(negedge clk);
        pulse_reset("rst_twait");
        repeat (40) @(negedge clk);
        check("twait_idle_start", tx_start, 0);
        s0 = start_cnt; p0 = exp_pushed;
        send_byte(8'h09);
        wait_drain("b9");
        check("b9_starts", start_cnt - s0, exp_pushed - p0);
        check("b9_level", fifo_level, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
